// File: rtl/stopwatch_pkg.sv
// Shared types and constants for the stopwatch controller and its prescaler.
package stopwatch_pkg;

  typedef enum logic [2:0] {
    IDLE,
    RUN,
    LAP,
    STOP,
    FULL
  } sw_state_t;

  localparam logic [3:0] BCD_MAX          = 4'd9;
  localparam int         TICK_DIV_DEFAULT = 1000000;

  function automatic logic bcd_is_max(input logic [3:0] digit);
    return digit == BCD_MAX;
  endfunction

endpackage

// File: rtl/stopwatch_ctrl_if.sv
// Button, counter-chain and display signals between the controller and its surroundings.
interface stopwatch_ctrl_if;

  logic       btn_ss;
  logic       btn_lr;
  logic [3:0] d1;
  logic [3:0] d2;
  logic [3:0] d3;
  logic [3:0] d4;
  logic       cnt_en;
  logic       cnt_rst;
  logic [3:0] disp_d1;
  logic [3:0] disp_d2;
  logic [3:0] disp_d3;
  logic [3:0] disp_d4;
  logic       lap_active;
  logic       full;

  modport master (
    output btn_ss, btn_lr, d1, d2, d3, d4,
    input  cnt_en, cnt_rst, disp_d1, disp_d2, disp_d3, disp_d4, lap_active, full
  );

  modport slave (
    input  btn_ss, btn_lr, d1, d2, d3, d4,
    output cnt_en, cnt_rst, disp_d1, disp_d2, disp_d3, disp_d4, lap_active, full
  );

endinterface

// File: rtl/sw_tick_gen.sv
// Prescaler counting 0..TICK_DIV-1 while run is high; wrap flags the last count of each period.
module sw_tick_gen
  import stopwatch_pkg::*;
#(
  parameter int TICK_DIV = TICK_DIV_DEFAULT
) (
  input  logic clk,
  input  logic reset,
  input  logic run,
  input  logic clear,
  output logic wrap
);

  localparam int             CW   = $clog2(TICK_DIV);
  localparam logic [CW-1:0]  LAST = CW'(TICK_DIV - 1);

  logic [CW-1:0] count;

  // Holding (rather than clearing) when run drops keeps the tick phase across a pause.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      count <= '0;
    end else if (clear) begin
      count <= '0;
    end else if (run) begin
      if (count == LAST) begin
        count <= '0;
      end else begin
        count <= count + 1'b1;
      end
    end
  end

  assign wrap = run && !clear && (count == LAST);

endmodule

// File: rtl/stopwatch_ctrl.sv
// Stopwatch control: button edge detection, five-state FSM, lap freeze register and display mux.
module stopwatch_ctrl
  import stopwatch_pkg::*;
#(
  parameter int TICK_DIV = TICK_DIV_DEFAULT
) (
  input  logic             clk,
  input  logic             reset,
  stopwatch_ctrl_if.slave  bus
);

  sw_state_t   state;
  sw_state_t   next_state;
  logic        ss_q;
  logic        lr_q;
  logic        ss_edge;
  logic        lr_edge;
  logic        wrap;
  logic        counting;
  logic        all_nines;
  logic        saturate;
  logic        go_idle;
  logic        rst_ext;
  logic        cnt_en_q;
  logic        cnt_rst_q;
  logic        lap_active_q;
  logic        full_q;
  logic [15:0] lap_q;

  assign ss_edge   = bus.btn_ss && !ss_q;
  assign lr_edge   = bus.btn_lr && !lr_q;
  assign counting  = (state == RUN) || (state == LAP);
  assign all_nines = bcd_is_max(bus.d1) && bcd_is_max(bus.d2) &&
                     bcd_is_max(bus.d3) && bcd_is_max(bus.d4);
  assign saturate  = wrap && all_nines;
  assign go_idle   = (next_state == IDLE) && (state != IDLE);

  sw_tick_gen #(
    .TICK_DIV (TICK_DIV)
  ) u_tick (
    .clk   (clk),
    .reset (reset),
    .run   (counting),
    .clear ((state == IDLE) || go_idle),
    .wrap  (wrap)
  );

  // Saturation outranks the buttons so 9999 can never be passed; ss outranks lr.
  always_comb begin
    next_state = state;
    case (state)
      IDLE: if (ss_edge) next_state = RUN;
      RUN: begin
        if (saturate)     next_state = FULL;
        else if (ss_edge) next_state = STOP;
        else if (lr_edge) next_state = LAP;
      end
      LAP: begin
        if (saturate)     next_state = FULL;
        else if (ss_edge) next_state = STOP;
        else if (lr_edge) next_state = RUN;
      end
      STOP: begin
        if (ss_edge)      next_state = RUN;
        else if (lr_edge) next_state = IDLE;
      end
      FULL: if (lr_edge) next_state = IDLE;
      default:            next_state = IDLE;
    endcase
  end

  // rst_ext stretches cnt_rst one full cycle past reset release so the counter chain clears.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state        <= IDLE;
      ss_q         <= 1'b0;
      lr_q         <= 1'b0;
      rst_ext      <= 1'b1;
      cnt_en_q     <= 1'b0;
      cnt_rst_q    <= 1'b1;
      lap_active_q <= 1'b0;
      full_q       <= 1'b0;
      lap_q        <= '0;
    end else begin
      state        <= next_state;
      ss_q         <= bus.btn_ss;
      lr_q         <= bus.btn_lr;
      rst_ext      <= 1'b0;
      cnt_rst_q    <= go_idle || rst_ext;
      cnt_en_q     <= wrap && !saturate && ((next_state == RUN) || (next_state == LAP));
      lap_active_q <= (next_state == LAP);
      full_q       <= (next_state == FULL);
      if ((state == RUN) && (next_state == LAP)) begin
        lap_q <= {bus.d4, bus.d3, bus.d2, bus.d1};
      end
    end
  end

  assign bus.cnt_en     = cnt_en_q;
  assign bus.cnt_rst    = cnt_rst_q;
  assign bus.lap_active = lap_active_q;
  assign bus.full       = full_q;
  assign bus.disp_d1    = lap_active_q ? lap_q[3:0]   : bus.d1;
  assign bus.disp_d2    = lap_active_q ? lap_q[7:4]   : bus.d2;
  assign bus.disp_d3    = lap_active_q ? lap_q[11:8]  : bus.d3;
  assign bus.disp_d4    = lap_active_q ? lap_q[15:12] : bus.d4;

endmodule

// File: doc/stopwatch_ctrl.md
STOPWATCH_CTRL -- requirements
Module: stopwatch_ctrl

Interface
REQ-001 Parameter TICK_DIV, default 1000000, SHALL be the number of clk cycles per count tick (100 Hz hundredths at 100 MHz); legal range >= 2.
REQ-002 clk  input  1  SHALL be the single clock; all state SHALL update on its rising edge.
REQ-003 reset  input  1  SHALL be the asynchronous, active-high reset.
REQ-004 btn_ss  input  1  SHALL be the start/stop button, debounced and synchronous to clk, level-sensitive.
REQ-005 btn_lr  input  1  SHALL be the lap/reset button, debounced and synchronous to clk, level-sensitive.
REQ-006 d1,d2,d3,d4  input  4 each  SHALL be the live BCD digits from the 4-digit counter chain (d1 least significant).
REQ-007 cnt_en  output  1  SHALL be the count enable to the least-significant counter stage.
REQ-008 cnt_rst  output  1  SHALL be the clear to all counter stages.
REQ-009 disp_d1..disp_d4  output  4 each  SHALL be the digits to display.
REQ-010 lap_active  output  1  SHALL be high while the display is frozen.
REQ-011 full  output  1  SHALL be high while in state FULL.

Function
REQ-012 Each button SHALL be rising-edge detected internally; the edge-detect register SHALL power up low.
REQ-013 A press seen in cycle n SHALL change state on the clk edge ending cycle n, so the new state is visible in cycle n+1.
REQ-014 The FSM SHALL have exactly five states: IDLE, RUN, LAP, STOP, FULL.
REQ-015 IDLE: ss -> RUN; lr ignored.
REQ-016 RUN: ss -> STOP; lr -> LAP.
REQ-017 LAP: ss -> STOP; lr -> RUN.
REQ-018 STOP: ss -> RUN; lr -> IDLE.
REQ-019 FULL: lr -> IDLE; ss ignored.
REQ-020 If both edges occur in the same cycle, ss SHALL take priority and lr SHALL be discarded.
REQ-021 The prescaler SHALL count 0..TICK_DIV-1 and wrap, only while in RUN or LAP.
REQ-022 The prescaler SHALL hold its value in STOP and FULL, so a resumed count keeps its phase.
REQ-023 The prescaler SHALL be zero in IDLE.
REQ-024 cnt_en SHALL be registered and high for exactly one cycle, in the cycle after the prescaler wraps, while in RUN or LAP.
REQ-025 When a wrap occurs with d4..d1 = 9,9,9,9, cnt_en SHALL stay low and the FSM SHALL enter FULL, so the count saturates at 9999 and never rolls to 0000.
REQ-026 cnt_rst SHALL be registered and high for exactly one cycle on every transition into IDLE, including from STOP and from FULL.
REQ-027 On RUN -> LAP, the lap register SHALL capture d1..d4 as sampled in that cycle.
REQ-028 disp_dN SHALL equal the lap register in LAP and the live dN in every other state.
REQ-029 lap_active SHALL equal (state == LAP).
REQ-030 Counting SHALL continue unaffected while in LAP.
REQ-031 LAP -> STOP SHALL release the freeze, so STOP always shows live digits.

Reset
REQ-032 While reset is asserted, the FSM SHALL be in IDLE and the prescaler SHALL be 0.
REQ-033 While reset is asserted, the lap register SHALL be 0000 and cnt_en, lap_active and full SHALL be 0.
REQ-034 cnt_rst SHALL be 1 while reset is asserted and for the first cycle after deassertion, so the counter chain clears even when its own reset is not tied to reset.
REQ-035 A reset asserted mid-RUN or mid-LAP SHALL abort immediately, with no cnt_en pulse afterwards until a new ss press.

Structure
REQ-036 Package stopwatch_pkg SHALL hold the state enum typedef sw_state_t, the BCD_MAX constant (4'd9) and the TICK_DIV default.
REQ-037 The prescaler SHALL be a separate sub-module sw_tick_gen (inputs run and clear; output a one-cycle wrap pulse).
REQ-038 The FSM, edge detection, lap register and display mux SHALL reside in stopwatch_ctrl.

Verification (TICK_DIV=4; counter chain model attached)
REQ-039 Reset, then ss pulse -> RUN next cycle; first cnt_en 4 clk later; cnt_en repeats every 4 clk; digits reach 0003 after 12 clk.
REQ-040 At count 0012 press lr -> disp shows 0012 and lap_active=1 while live digits advance to 0015; lr again -> disp tracks live.
REQ-041 ss in RUN at prescaler=2 -> no cnt_en while in STOP; ss again -> first cnt_en after 2 clk.
REQ-042 Preload 9998 and RUN -> one cnt_en to 9999, then FULL=1, cnt_en stays 0 and digits hold 9999; lr -> IDLE, cnt_rst pulse, digits 0000.
REQ-043 ss and lr edges in the same cycle from RUN -> STOP (lap register unchanged).
REQ-044 Assert reset in LAP at count 0050 -> all outputs 0, cnt_rst=1, state IDLE, no cnt_en afterwards.
